// File: rtl/bus_interface_unit_pkg.sv
// Shared constants for the bus interface unit: bus phase states, address-select
// codes (also used by the decoder) and the reset vector location.
package bus_interface_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADR_LO = 2'd1,
      ADR_HI = 2'd2,
      DATA   = 2'd3
   } biuState_e;

   localparam logic [1:0]  ADDR_SEL_PC  = 2'd0;
   localparam logic [1:0]  ADDR_SEL_MEM = 2'd1;
   localparam logic [1:0]  ADDR_SEL_ALU = 2'd2;
   localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

   // The reserved select code falls back to the PC.
   function automatic logic [15:0] selectAddress(input logic [1:0]  sel,
                                                 input logic [15:0] pcValue,
                                                 input logic [15:0] memAddr,
                                                 input logic [7:0]  aluAddr);
      case (sel)
         ADDR_SEL_MEM: return memAddr;
         ADDR_SEL_ALU: return {8'h00, aluAddr};
         default:      return pcValue;
      endcase
   endfunction

endpackage

// File: rtl/bus_interface_unit_program_counter.sv
// 16-bit program counter with async reset, increment and parallel load.
// Load takes priority over increment.
module program_counter (
   input  logic        clk,
   input  logic        res,
   input  logic        inc_i,
   input  logic        load_i,
   input  logic [15:0] loadValue_i,
   output logic [15:0] pc_o
);

   logic [15:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = loadValue_i;
      end else if (inc_i) begin
         pc_d = pc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pc_q <= 16'h0000;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/bus_interface_unit.sv
// Bus interface unit: owns the PC and runs three-phase accesses on the muxed uio pins.
// Optional BIU_RESET_VECTOR_EN fetches the PC from $FFFC/$FFFD after reset.
module bus_interface_unit
   import bus_interface_unit_pkg::*;
(
   input  logic        clk,
   input  logic        res,
   input  logic        req,
   input  logic        rw,
   input  logic [1:0]  address_select,
   input  logic [15:0] memory_address,
   input  logic [7:0]  alu_result,
   input  logic        pc_enable,
   input  logic [7:0]  data_out,
   output logic [7:0]  data_in,
   output logic        done,
   output logic        busy,
   output logic [15:0] pc,
   input  logic [7:0]  bus_ad_in,
   output logic [7:0]  bus_ad_out,
   output logic [7:0]  bus_ad_oe,
   output logic        bus_alel,
   output logic        bus_aleh,
   output logic        bus_rw,
   output logic        bus_strobe
);

   biuState_e   state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  dataIn_q, dataIn_d;
   logic        done_q, done_d;
   logic        pcInc, pcLoad;
   logic [15:0] pcLoadValue;

`ifdef BIU_RESET_VECTOR_EN
   logic        vecPending_q, vecPending_d;
   logic        vecActive_q, vecActive_d;
   logic        vecHigh_q, vecHigh_d;
   logic [7:0]  vecLo_q, vecLo_d;
`endif

   program_counter u_pc (
      .clk         (clk),
      .res         (res),
      .inc_i       (pcInc),
      .load_i      (pcLoad),
      .loadValue_i (pcLoadValue),
      .pc_o        (pc)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;
      dataIn_d    = dataIn_q;
      done_d      = 1'b0;
      pcInc       = pc_enable;
      pcLoad      = 1'b0;
      pcLoadValue = 16'h0000;
`ifdef BIU_RESET_VECTOR_EN
      vecPending_d = vecPending_q;
      vecActive_d  = vecActive_q;
      vecHigh_d    = vecHigh_q;
      vecLo_d      = vecLo_q;
      if (vecPending_q || vecActive_q) begin
         pcInc = 1'b0;
      end
`endif
      case (state_q)
         IDLE: begin
`ifdef BIU_RESET_VECTOR_EN
            if (vecPending_q) begin
               state_d      = ADR_LO;
               addr_d       = RESET_VECTOR;
               rw_d         = 1'b1;
               vecPending_d = 1'b0;
               vecActive_d  = 1'b1;
               vecHigh_d    = 1'b0;
            end else
`endif
            if (req) begin
               state_d = ADR_LO;
               addr_d  = selectAddress(address_select, pc, memory_address, alu_result);
               rw_d    = rw;
               wdata_d = data_out;
            end
         end
         ADR_LO: state_d = ADR_HI;
         ADR_HI: state_d = DATA;
         DATA: begin
`ifdef BIU_RESET_VECTOR_EN
            // Vector reads chain straight into the high-byte fetch, then load the PC silently.
            if (vecActive_q) begin
               if (!vecHigh_q) begin
                  state_d   = ADR_LO;
                  vecLo_d   = bus_ad_in;
                  vecHigh_d = 1'b1;
                  addr_d    = RESET_VECTOR + 16'd1;
               end else begin
                  state_d     = IDLE;
                  vecActive_d = 1'b0;
                  vecHigh_d   = 1'b0;
                  pcLoad      = 1'b1;
                  pcLoadValue = {bus_ad_in, vecLo_q};
               end
            end else
`endif
            begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (rw_q) begin
                  dataIn_d = bus_ad_in;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q  <= IDLE;
         addr_q   <= 16'h0000;
         rw_q     <= 1'b1;
         wdata_q  <= 8'h00;
         dataIn_q <= 8'h00;
         done_q   <= 1'b0;
`ifdef BIU_RESET_VECTOR_EN
         vecPending_q <= 1'b1;
         vecActive_q  <= 1'b0;
         vecHigh_q    <= 1'b0;
         vecLo_q      <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         dataIn_q <= dataIn_d;
         done_q   <= done_d;
`ifdef BIU_RESET_VECTOR_EN
         vecPending_q <= vecPending_d;
         vecActive_q  <= vecActive_d;
         vecHigh_q    <= vecHigh_d;
         vecLo_q      <= vecLo_d;
`endif
      end
   end

   // Pin drive is decoded purely from the registered state, so reset clears it at once.
   always_comb begin
      bus_ad_out = 8'h00;
      bus_ad_oe  = 8'h00;
      bus_alel   = 1'b0;
      bus_aleh   = 1'b0;
      bus_rw     = 1'b1;
      bus_strobe = 1'b0;
      case (state_q)
         ADR_LO: begin
            bus_ad_out = addr_q[7:0];
            bus_ad_oe  = 8'hFF;
            bus_alel   = 1'b1;
         end
         ADR_HI: begin
            bus_ad_out = addr_q[15:8];
            bus_ad_oe  = 8'hFF;
            bus_aleh   = 1'b1;
         end
         DATA: begin
            bus_rw     = rw_q;
            bus_strobe = 1'b1;
            if (!rw_q) begin
               bus_ad_out = wdata_q;
               bus_ad_oe  = 8'hFF;
            end
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign data_in = dataIn_q;

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Responder side of the control interface produced by the instruction decoder: it owns the 16-bit program counter, accepts bus-cycle requests (address source, direction, write data) and executes them on the chip's multiplexed 8-bit external address/data pins. Each access is a fixed three-phase sequence: address low, address high, then data. Read data is returned to the core. It sits between the core datapath (decoder, ALU, data buffer) and the TinyTapeout `uio` pins.

## Interface
Parameters:
- none; all constants come from the shared include.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  single system clock, rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `req`  in  1  single-cycle request pulse; honoured only while `busy`=0.
- `rw`  in  1  1 = read, 0 = write.
- `address_select`  in  2  address source: 0 = PC, 1 = `memory_address`, 2 = {8'h00, `alu_result`}, 3 = reserved (treated as PC).
- `memory_address`  in  16  explicit address.
- `alu_result`  in  8  zero-page indexed address from the ALU.
- `pc_enable`  in  1  increment PC this cycle.
- `data_out`  in  8  write data from the data buffer.
- `data_in`  out  8  registered read data.
- `done`  out  1  one-cycle pulse when an access completes.
- `busy`  out  1  high in any non-IDLE state.
- `pc`  out  16  current program counter.
- `bus_ad_in`  in  8  `uio_in`.
- `bus_ad_out`  out  8  `uio_out`.
- `bus_ad_oe`  out  8  `uio_oe`.
- `bus_alel`  out  1  latch-enable for the address low byte.
- `bus_aleh`  out  1  latch-enable for the address high byte.
- `bus_rw`  out  1  external direction, 1 = read.
- `bus_strobe`  out  1  data phase strobe.

## Operation
- States: IDLE, ADR_LO, ADR_HI, DATA.
- IDLE → ADR_LO on `req`=1.
  - The same edge latches the selected address, `rw` and `data_out`.
  - For `address_select`=0, the latched address is the PC value before any same-edge increment.
- ADR_LO → ADR_HI → DATA → IDLE unconditionally.
- Outputs are Moore-decoded from registered state and latches:
  - ADR_LO: `bus_ad_out`=addr[7:0], `bus_ad_oe`=8'hFF, `bus_alel`=1.
  - ADR_HI: `bus_ad_out`=addr[15:8], `bus_ad_oe`=8'hFF, `bus_aleh`=1.
  - DATA, write: `bus_ad_out`=latched data, `bus_ad_oe`=8'hFF, `bus_rw`=0, `bus_strobe`=1.
  - DATA, read: `bus_ad_oe`=8'h00, `bus_rw`=1, `bus_strobe`=1; `data_in` captures `bus_ad_in` on the edge leaving DATA.
- `done` is registered. It is high for the first IDLE cycle after DATA, for reads and writes.
- `req` while `busy`=1 is ignored: it is not queued and has no side effects.
- PC:
  - Increments by 1 on any edge where `pc_enable`=1, independent of bus state.
  - Wraps 16'hFFFF → 16'h0000.
- Reset (any time, including mid-access):
  - State → IDLE; in-flight access abandoned with no `done`.
  - `pc`=16'h0000, `data_in`=8'h00, `busy`=0, `done`=0.
  - `bus_ad_out`=8'h00, `bus_ad_oe`=8'h00, `bus_alel`=`bus_aleh`=`bus_strobe`=0, `bus_rw`=1.

## Timing
- `req` sampled at edge E0.
- ADR_LO in cycle 1, ADR_HI in cycle 2, DATA in cycle 3.
- `done` and valid `data_in` in cycle 4.
- A `req` in the `done` cycle is accepted, so back-to-back throughput is one access per 4 cycles.
- Outside DATA, `bus_rw`=1 and `bus_strobe`=0. In IDLE, `bus_ad_oe`=8'h00.

## Configuration
- `BIU_RESET_VECTOR_EN` defined:
  - After `res` deasserts, the unit performs two internal reads, $FFFC then $FFFD, using the normal three-phase sequence.
  - It then loads `pc` = {byte@$FFFD, byte@$FFFC}.
  - `busy`=1 for all 6 cycles; `req` and `pc_enable` are ignored; no `done` pulses.
  - The internal phase tracks low/high vector byte.
- `BIU_RESET_VECTOR_EN` undefined:
  - `pc` stays 16'h0000 after reset and the unit idles immediately.

## Structure
- Shared include `inc/bus_interface.vh` holds:
  - State encodings.
  - Address-select codes: `ADDR_SEL_PC`, `ADDR_SEL_MEM`, `ADDR_SEL_ALU`.
  - Reset vector address 16'hFFFC.
  - The decoder uses the same address-select codes.
- One sub-module: `program_counter`, a 16-bit register with async reset, increment and parallel load. The parallel load is used only by the vector fetch; load wins over increment.

## Test plan
- Read via PC: `pc`=16'h0200, `req`, `rw`=1, select 0, external memory returns 8'hA9.
  - Expect `bus_ad_out` 8'h00 in cycle 1, then 8'h02 in cycle 2.
  - Expect `bus_ad_oe` 8'h00 in cycle 3.
  - Expect `done` in cycle 4 with `data_in`=8'hA9.
- Write via `memory_address`=16'h1234, `data_out`=8'h5A.
  - Expect phases 8'h34, 8'h12, 8'h5A with `bus_ad_oe`=8'hFF and `bus_rw`=0 only in DATA.
- ALU-indexed read, `alu_result`=8'h85: expect address phases 8'h85 then 8'h00.
- Busy and back-to-back:
  - A second `req` in cycle 2 is ignored; no second access occurs.
  - A `req` in the `done` cycle starts the next ADR_LO one cycle later.
- PC wrap and reset:
  - `pc`=16'hFFFF with `pc_enable` gives 16'h0000.
  - `res` asserted during ADR_HI drops all outputs to reset values immediately, with no `done`.
- With `BIU_RESET_VECTOR_EN`: memory holds $FFFC=8'h00, $FFFD=8'h80.
  - After reset, expect 6 `busy` cycles, then `pc`=16'h8000 and no `done`.
